sub_serial_nb: RTL
==================

// Module: sub_serial_nb
//
// PURPOSE
// - Multi-cycle bit-serial n-bit subtractor: diff = a - b - bin, with borrow-out bo.
// - It is the subtract-direction companion to the team's n-bit combinational adder.
// - It processes one bit per clock, LSB first, which trades latency for a single 1-bit slice.
// - It sits beside the ALU datapath and is driven by a start/busy/done handshake from the controlling FSM.
//
// PARAMETERS
// - n  8  operand / result width in bits (n >= 2)
//
// PORTS
// - clk    in   1  system clock; all state changes on the rising edge
// - rst    in   1  reset, asynchronous, active-high
// - start  in   1  request pulse; sampled only in IDLE
// - a      in   n  minuend; sampled on the edge that accepts start
// - b      in   n  subtrahend; sampled on the edge that accepts start
// - bin    in   1  borrow-in; sampled on the edge that accepts start
// - busy   out  1  high in every state except IDLE
// - done   out  1  one-cycle pulse; result valid
// - diff   out  n  result; held stable until the next completion
// - bo     out  1  borrow-out, i.e. unsigned a < b + bin; held with diff
//
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, busy=0, done=0, diff=0, bo=0. Internal shift registers, counter and borrow are also cleared.
// - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE:
//   - start=1 on an edge: latch a, b into shift regs; borrow reg = bin; bit count = 0; go to SHIFT.
//   - start=0: stay in IDLE.
// - SHIFT: one bit per edge.
//   - d = a0 ^ b0 ^ brw.
//   - brw' = (~a0 & b0) | (~(a0 ^ b0) & brw).
//   - d is shifted into the result reg from the MSB side; the operand regs shift right.
//   - After the n-th SHIFT edge: copy result to diff, final brw to bo, go to DONE.
// - DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
// - Latency: done is high after exactly n+1 rising edges, counting the edge that accepted start. For n=8, that is the 9th edge.
// - diff and bo change only on entry to DONE. They never show partial results and are held through IDLE.
// - start while busy (SHIFT or DONE) is ignored. It is not queued. Operands are not re-sampled.
// - Back-to-back operation: start may be held high; a new operation is accepted on the first IDLE edge. Throughput is one result per n+2 cycles.
// - Arithmetic is modulo 2^n: results wrap (0x00 - 0x01 = 0xFF, bo=1). a == b with bin=0 gives diff=0, bo=0.
// - Changes to a, b or bin after acceptance have no effect.
// - The bit counter is $clog2(n) bits wide and terminates at n-1; no off-by-one at wrap.
//
// CONFIGURATION
// - Macro: SUB_SERIAL_OVF_EN.
// - Defined:
//   - Adds output port `ovf  out  1`, the signed two's-complement overflow flag.
//   - ovf = (a[n-1] ^ b[n-1]) & (diff[n-1] ^ a[n-1]), using the latched operand MSBs.
//   - ovf updates together with diff/bo on DONE entry and resets to 0.
// - Undefined: the port and its logic are absent; all other behaviour is identical.
//
// STRUCTURE
// - Package sub_serial_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} sub_state_t.
//   - Default width constant SUB_N_DEFAULT = 8.
// - Sub-module full_sub_1b: combinational 1-bit full subtractor.
//   - Ports: x, y, bi -> d, bo.
//   - Instantiated once as the serial slice.
// - Top level holds the FSM, counter, operand/result shift registers and output registers.
//
// TESTING
// - Reset: assert rst mid-cycle -> busy/done/diff/bo immediately 0; stay IDLE with start=0.
// - Basic: n=8, a=0x5A, b=0x23, bin=0 -> diff=0x37, bo=0; done on 9th edge, high for 1 cycle.
// - Wrap/borrow:
//   - a=0x00, b=0x01, bin=0 -> diff=0xFF, bo=1.
//   - a=0x10, b=0x0F, bin=1 -> diff=0x00, bo=0.
// - Busy protection: start a=0x05, b=0x03; re-pulse start with a=0xFF, b=0x00 during SHIFT -> diff=0x02 only, single done.
// - Reset mid-op: assert rst at 4th SHIFT edge -> all outputs 0, IDLE. The next op a=0x80, b=0x7F gives diff=0x01, bo=0.
// - OVF (macro defined):
//   - a=0x80, b=0x01 -> diff=0x7F, bo=0, ovf=1.
//   - a=0x7F, b=0xFF -> diff=0x80, bo=1, ovf=1.
//   - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } sub_state_t;

    localparam int unsigned SUB_N_DEFAULT = 8;

endpackage

// File: rtl/full_sub_1b.sv
// Combinational 1-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_sub_1b (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/sub_serial_nb.sv
// Bit-serial n-bit subtractor (diff = a - b - bin), one bit per clock, LSB first.
// Optional signed overflow output enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial_nb
    import sub_serial_pkg::*;
#(
    parameter int unsigned n = SUB_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] diff,
`ifdef SUB_SERIAL_OVF_EN
    output logic         ovf,
`endif
    output logic         bo
);

    localparam int unsigned CNT_W = $clog2(n);

    sub_state_t         r_state;
    logic [n-1:0]       r_a;
    logic [n-1:0]       r_b;
    logic [n-2:0]       r_res;
    logic               r_brw;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [n-1:0]       r_diff;
    logic               r_bo;

    logic               w_d;
    logic               w_bo;
    logic [n-1:0]       w_res_next;

    full_sub_1b u_slice (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_brw),
        .d  (w_d),
        .bo (w_bo)
    );

    // New difference bit enters from the MSB side; bit 0 of this vector is the oldest bit.
    assign w_res_next = {w_d, r_res};

`ifdef SUB_SERIAL_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_a_msb <= a[n-1];
            r_b_msb <= b[n-1];
        end else if (r_state == ST_SHIFT && r_cnt == CNT_W'(n-1)) begin
            r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bo    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_brw   <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_brw <= w_bo;
                    r_res <= w_res_next[n-1:1];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(n-1)) begin
                        r_cnt   <= '0;
                        r_diff  <= w_res_next;
                        r_bo    <= w_bo;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bo   = r_bo;

endmodule
